// File: rtl/ksa_multiplier_delayed.sv
// Two-stage unsigned WIDTH x WIDTH multiplier: split-operand partial products,
// then an exact recombination built from Kogge-Stone parallel-prefix adders.

module ksa_adder #(
    parameter int N = 8
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] sum_o
);
    localparam int L = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0] g [0:L];
    logic [N-1:0] p [0:L];

    // Level k merges each (G,P) pair with the one 2^k bits below it.
    always_comb begin
        g[0] = a_i & b_i;
        p[0] = a_i ^ b_i;
        for (int k = 0; k < L; k++) begin
            g[k+1] = g[k];
            p[k+1] = p[k];
            for (int i = (1 << k); i < N; i++) begin
                g[k+1][i] = g[k][i] | (p[k][i] & g[k][i-(1<<k)]);
                p[k+1][i] = p[k][i] & p[k][i-(1<<k)];
            end
        end
    end

    // Carry into bit i is the group generate of bits i-1..0; carry-in is 0.
    assign sum_o = p[0] ^ {g[L][N-2:0], 1'b0};
endmodule

module ksa_multiplier_delayed #(
    parameter int WIDTH = 28
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in1,
    input  logic [WIDTH-1:0]     in2,
    output logic [2*WIDTH-1:0]   out
);
    localparam int H  = (WIDTH + 1) / 2;
    localparam int HW = 2 * H;
    localparam int MW = HW + 1;
    localparam int FW = 4 * H;
    localparam int OW = 2 * WIDTH;

    logic [HW-1:0] a_ext, b_ext;
    logic [H-1:0]  a_lo, a_hi, b_lo, b_hi;

    logic [HW-1:0] ll_p1_d, lh_p1_d, hl_p1_d, hh_p1_d;
    logic [HW-1:0] ll_p1_q, lh_p1_q, hl_p1_q, hh_p1_q;

    logic [MW-1:0] mid_sum;
    logic [FW-1:0] full_sum;
    logic [OW-1:0] out_p2_d, out_p2_q;

    // Odd widths are padded to an even split so both halves are H bits.
    assign a_ext = HW'(in1);
    assign b_ext = HW'(in2);
    assign a_lo  = a_ext[H-1:0];
    assign a_hi  = a_ext[HW-1:H];
    assign b_lo  = b_ext[H-1:0];
    assign b_hi  = b_ext[HW-1:H];

    assign ll_p1_d = HW'(a_lo) * HW'(b_lo);
    assign lh_p1_d = HW'(a_lo) * HW'(b_hi);
    assign hl_p1_d = HW'(a_hi) * HW'(b_lo);
    assign hh_p1_d = HW'(a_hi) * HW'(b_hi);

    // ---- stage 1 -> stage 2 boundary: partial products ----
    always_ff @(posedge clk) begin
        if (rst) begin
            ll_p1_q <= '0;
            lh_p1_q <= '0;
            hl_p1_q <= '0;
            hh_p1_q <= '0;
        end else begin
            ll_p1_q <= ll_p1_d;
            lh_p1_q <= lh_p1_d;
            hl_p1_q <= hl_p1_d;
            hh_p1_q <= hh_p1_d;
        end
    end

    // Cross terms get one extra bit so their sum never wraps.
    ksa_adder #(.N(MW)) u_mid_add (
        .a_i   (MW'(lh_p1_q)),
        .b_i   (MW'(hl_p1_q)),
        .sum_o (mid_sum)
    );

    // hh<<2H + ll never overlap, so they concatenate; only the cross term is added.
    ksa_adder #(.N(FW)) u_final_add (
        .a_i   ({hh_p1_q, ll_p1_q}),
        .b_i   (FW'({mid_sum, {H{1'b0}}})),
        .sum_o (full_sum)
    );

    assign out_p2_d = OW'(full_sum);

    // ---- stage 2 boundary: registered product ----
    always_ff @(posedge clk) begin
        if (rst) begin
            out_p2_q <= '0;
        end else begin
            out_p2_q <= out_p2_d;
        end
    end

    assign out = out_p2_q;
endmodule

// File: tb/tb_ksa_multiplier_delayed.sv
// Bench for ksa_multiplier_delayed at WIDTH=8, 28 and 13 against a delayed
// arithmetic product model, plus directed literal cases and standalone adder checks.

module tb_ksa_multiplier_delayed;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;

    logic [7:0]  a8 = '0,  b8 = '0;
    logic [15:0] o8;
    logic [27:0] a28 = '0, b28 = '0;
    logic [55:0] o28;
    logic [12:0] a13 = '0, b13 = '0;
    logic [25:0] o13;

    logic [27:0] ka = '0, kb = '0, ks;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    ksa_multiplier_delayed #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .in1(a8),  .in2(b8),  .out(o8));
    ksa_multiplier_delayed #(.WIDTH(28)) u_dut28 (.clk(clk), .rst(rst), .in1(a28), .in2(b28), .out(o28));
    ksa_multiplier_delayed #(.WIDTH(13)) u_dut13 (.clk(clk), .rst(rst), .in1(a13), .in2(b13), .out(o13));

    ksa_adder #(.N(28)) u_ksa (.a_i(ka), .b_i(kb), .sum_o(ks));

    // Reference: exact product, delayed through two stages, cleared by reset.
    logic [63:0] m8_1 = '0,  m8_2 = '0;
    logic [63:0] m28_1 = '0, m28_2 = '0;
    logic [63:0] m13_1 = '0, m13_2 = '0;

    always @(posedge clk) begin
        if (rst) begin
            m8_1 <= '0;  m8_2 <= '0;
            m28_1 <= '0; m28_2 <= '0;
            m13_1 <= '0; m13_2 <= '0;
        end else begin
            m8_1  <= 64'(a8)  * 64'(b8);
            m28_1 <= 64'(a28) * 64'(b28);
            m13_1 <= 64'(a13) * 64'(b13);
            m8_2  <= m8_1;
            m28_2 <= m28_1;
            m13_2 <= m13_1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_w8",  64'(o8),  m8_2);
            chk("model_w28", 64'(o28), m28_2);
            chk("model_w13", 64'(o13), m13_2);
        end
    end

    function automatic logic [63:0] pick();
        logic [63:0] r;
        int mode;
        r    = {$urandom, $urandom};
        mode = $urandom_range(0, 15);
        if (mode == 0) r = '0;
        else if (mode == 1) r = '1;
        return r;
    endfunction

    task automatic drv(input logic [27:0] x, input logic [27:0] y);
        @(posedge clk);
        #1;
        a28 = x;
        b28 = y;
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_w8",  64'(o8),  64'd0);
        chk("reset_w28", 64'(o28), 64'd0);
        chk("reset_w13", 64'(o13), 64'd0);
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Unit product 1.0 x 1.0
        drv(28'h4000000, 28'h4000000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("unit", 64'(o28), 64'h0010000000000000);

        // Max operands
        drv(28'hFFFFFFF, 28'hFFFFFFF);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("max", 64'(o28), 64'h00FFFFFFE0000001);

        // 0.75 x 3.0
        drv(28'h3000000, 28'hC000000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("fixed", 64'(o28), 64'h0024000000000000);

        // Back-to-back stream
        drv(28'd1, 28'd1);
        drv(28'd0, 28'd5);
        drv(28'd3, 28'd7);
        @(negedge clk);
        chk("stream0", 64'(o28), 64'd1);
        @(negedge clk);
        chk("stream1", 64'(o28), 64'd0);
        @(negedge clk);
        chk("stream2", 64'(o28), 64'd21);

        // Reset mid-flight
        drv(28'd5, 28'd6);
        @(posedge clk);
        #1;
        rst = 1'b1;
        a28 = 28'd7;
        b28 = 28'd9;
        @(posedge clk);
        #1;
        rst = 1'b0;
        a28 = 28'd2;
        b28 = 28'd3;
        @(negedge clk);
        chk("rst_flush0", 64'(o28), 64'd0);
        @(negedge clk);
        chk("rst_flush1", 64'(o28), 64'd0);
        @(negedge clk);
        chk("rst_next", 64'(o28), 64'd6);

        // Standalone adder: wrap-around and two's-complement subtract
        ka = 28'hFFFFFFF; kb = 28'd1; #1;
        chk("ksa_wrap", 64'(ks), 64'd0);
        ka = 28'hC000000; kb = ~28'h4000000 + 28'd1; #1;
        chk("ksa_3_minus_1", 64'(ks), 64'h8000000);
        for (int n = 0; n < 20; n++) begin
            ka = 28'($urandom);
            kb = 28'($urandom);
            #1;
            chk("ksa_rand", 64'(ks), 64'(28'(ka + kb)));
        end

        // Random sweep with occasional resets
        for (int n = 0; n < 10500; n++) begin
            @(posedge clk);
            #1;
            rst = ($urandom_range(0, 499) == 0);
            a8  = 8'(pick());  b8  = 8'(pick());
            a28 = 28'(pick()); b28 = 28'(pick());
            a13 = 13'(pick()); b13 = 13'(pick());
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
